// File: rtl/nubus_pkg.sv
// Shared definitions for the NuBus master controller: state encoding,
// default configuration constants and the requester-index width helper.
package nubus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_LOCK_ATN,
    ST_START,
    ST_DATA,
    ST_NULL_ATN
  } nub_state_e;

  localparam int NUBUS_NUM_REQ    = 2;
  localparam int NUBUS_TMO_W      = 8;
  localparam int NUBUS_TMO_CYCLES = 200;

  // Index width for n requesters, never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nubus_rr_sel.sv
// Round-robin requester picker: returns the first valid index found when
// searching upward (with wrap) from the start pointer.
module nubus_rr_sel
  import nubus_pkg::*;
#(
  parameter int NUM_REQ = NUBUS_NUM_REQ
) (
  input  logic [NUM_REQ-1:0]            valid,
  input  logic [sel_width(NUM_REQ)-1:0] start,
  output logic [sel_width(NUM_REQ)-1:0] idx,
  output logic                          any
);

  localparam int SEL_W = sel_width(NUM_REQ);
  localparam int PW    = SEL_W + 1;

  logic [PW-1:0] pos;

  // Walk from the farthest candidate back toward start so the nearest wins.
  always_comb begin
    idx = '0;
    any = 1'b0;
    pos = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      pos = {1'b0, start} + PW'(k);
      if (pos >= PW'(NUM_REQ)) pos = pos - PW'(NUM_REQ);
      if (valid[pos[SEL_W-1:0]]) begin
        idx = pos[SEL_W-1:0];
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nubus_master_mc.sv
// Multi-requester NuBus master: arbitration, address/data cycles, locked
// sequences. Define NUBUS_MASTER_TIMEOUT_EN to enable the ACK-wait abort.
module nubus_master_mc
  import nubus_pkg::*;
#(
  parameter int NUM_REQ    = NUBUS_NUM_REQ,
  parameter int TMO_W      = NUBUS_TMO_W,
  parameter int TMO_CYCLES = NUBUS_TMO_CYCLES
) (
  input  logic                          nub_clkn,
  input  logic                          nub_reset,
  input  logic                          nub_rqstn,
  input  logic                          nub_startn,
  input  logic                          nub_ackn,
  input  logic                          arb_grant,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_lock,
  output logic [NUM_REQ-1:0]            req_done,
  output logic [NUM_REQ-1:0]            req_err,
  output logic [sel_width(NUM_REQ)-1:0] req_sel,
  output logic                          arbcy,
  output logic                          adrcy,
  output logic                          dtacy,
  output logic                          owner,
  output logic                          busy,
  output logic                          locked,
  output logic                          timeout_o
);

  localparam int SEL_W = sel_width(NUM_REQ);

  if (NUM_REQ < 1 || NUM_REQ > 8 || TMO_CYCLES < 1 || TMO_CYCLES >= (1 << TMO_W)) begin : g_bad_cfg
    $error("nubus_master_mc: parameter out of range");
  end

  nub_state_e       state;
  logic             arbdn;
  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] rr_idx;
  logic             rr_any;
  logic             bus_start;
  logic             bus_ack;
  logic             bus_rqst;
  logic             win;

  assign bus_start = ~nub_startn;
  assign bus_ack   = ~nub_ackn;
  assign bus_rqst  = ~nub_rqstn;
  assign win       = arbcy & arbdn & arb_grant &
                     ((~busy & ~bus_start) | (busy & bus_ack));

  function automatic logic [NUM_REQ-1:0] sel_onehot(input logic [SEL_W-1:0] s);
    return NUM_REQ'(1) << s;
  endfunction

  nubus_rr_sel #(.NUM_REQ(NUM_REQ)) u_rr_sel (
    .valid (req_valid),
    .start (rr_ptr),
    .idx   (rr_idx),
    .any   (rr_any)
  );

  // Foreign-transaction tracker and the one-clock arbitration delay flag.
  always_ff @(posedge nub_clkn) begin
    if (nub_reset) begin
      busy  <= 1'b0;
      arbdn <= 1'b0;
    end else begin
      busy  <= busy ? ~bus_ack : (bus_start & ~bus_ack);
      arbdn <= arbcy & ~bus_start;
    end
  end

`ifdef NUBUS_MASTER_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt;
`else
  assign req_err   = '0;
  assign timeout_o = 1'b0;
`endif

  always_ff @(posedge nub_clkn) begin
    if (nub_reset) begin
      state    <= ST_IDLE;
      req_sel  <= '0;
      rr_ptr   <= '0;
      req_done <= '0;
      arbcy    <= 1'b0;
      adrcy    <= 1'b0;
      dtacy    <= 1'b0;
      owner    <= 1'b0;
      locked   <= 1'b0;
`ifdef NUBUS_MASTER_TIMEOUT_EN
      req_err   <= '0;
      timeout_o <= 1'b0;
      tmo_cnt   <= '0;
`endif
    end else begin
      req_done <= '0;
`ifdef NUBUS_MASTER_TIMEOUT_EN
      req_err   <= '0;
      timeout_o <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (rr_any && !bus_rqst) begin
            state   <= ST_ARB;
            arbcy   <= 1'b1;
            req_sel <= rr_idx;
            rr_ptr  <= (rr_idx == SEL_W'(NUM_REQ - 1)) ? '0 : rr_idx + 1'b1;
          end
        end
        ST_ARB: begin
          if (win) begin
            owner <= 1'b1;
            adrcy <= 1'b1;
            // A locked sequence keeps arbcy asserted until NULL_ATN ends.
            if (req_lock[req_sel]) begin
              state  <= ST_LOCK_ATN;
              locked <= 1'b1;
            end else begin
              state <= ST_START;
              arbcy <= 1'b0;
            end
          end
        end
        ST_LOCK_ATN: state <= ST_START;
        ST_START: begin
          state <= ST_DATA;
          adrcy <= 1'b0;
          dtacy <= 1'b1;
        end
        ST_DATA: begin
          if (bus_ack) begin
            dtacy    <= 1'b0;
            req_done <= sel_onehot(req_sel);
            if (locked) begin
              state <= ST_NULL_ATN;
              adrcy <= 1'b1;
            end else begin
              state <= ST_IDLE;
              owner <= 1'b0;
            end
`ifdef NUBUS_MASTER_TIMEOUT_EN
            tmo_cnt <= '0;
          end else if (tmo_cnt == TMO_W'(TMO_CYCLES - 1)) begin
            state     <= ST_IDLE;
            tmo_cnt   <= '0;
            dtacy     <= 1'b0;
            owner     <= 1'b0;
            locked    <= 1'b0;
            arbcy     <= 1'b0;
            timeout_o <= 1'b1;
            req_done  <= sel_onehot(req_sel);
            req_err   <= sel_onehot(req_sel);
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
`endif
          end
        end
        ST_NULL_ATN: begin
          state  <= ST_IDLE;
          adrcy  <= 1'b0;
          owner  <= 1'b0;
          locked <= 1'b0;
          arbcy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nubus_master_mc.sv
// Bench for nubus_master_mc: directed transaction table, hand sequences for
// busy/reset/no-ACK corners, and randomized transactions against a model.
module tb_nubus_master_mc;

  localparam int NR = 2;

  logic          nub_clkn = 1'b0;
  logic          nub_reset;
  logic          nub_rqstn;
  logic          nub_startn;
  logic          nub_ackn;
  logic          arb_grant;
  logic [NR-1:0] req_valid;
  logic [NR-1:0] req_lock;
  logic [NR-1:0] req_done;
  logic [NR-1:0] req_err;
  logic [0:0]    req_sel;
  logic          arbcy, adrcy, dtacy, owner, busy, locked, timeout_o;

  always #5 nub_clkn = ~nub_clkn;

  nubus_master_mc #(.NUM_REQ(NR), .TMO_W(8), .TMO_CYCLES(5)) dut (
    .nub_clkn   (nub_clkn),
    .nub_reset  (nub_reset),
    .nub_rqstn  (nub_rqstn),
    .nub_startn (nub_startn),
    .nub_ackn   (nub_ackn),
    .arb_grant  (arb_grant),
    .req_valid  (req_valid),
    .req_lock   (req_lock),
    .req_done   (req_done),
    .req_err    (req_err),
    .req_sel    (req_sel),
    .arbcy      (arbcy),
    .adrcy      (adrcy),
    .dtacy      (dtacy),
    .owner      (owner),
    .busy       (busy),
    .locked     (locked),
    .timeout_o  (timeout_o)
  );

  typedef struct {
    logic [NR-1:0] v;
    logic [NR-1:0] lk;
    int            d;
    bit            drop;
    int            sel;
    int            arb;
    int            adr;
    int            dta;
    int            own;
    int            lck;
  } vec_t;

  int n_chk = 0;
  int n_err = 0;
  int rr_next = 0;
  int c_arb, c_adr, c_dta, c_own, c_lck, c_done, c_err, c_tmo;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge nub_clkn);
    #1;
  endtask

  function automatic logic [31:0] outs();
    return 32'({req_done, req_err, req_sel, arbcy, adrcy, dtacy, owner, busy, locked, timeout_o});
  endfunction

  task automatic clr_cnt();
    c_arb = 0; c_adr = 0; c_dta = 0; c_own = 0;
    c_lck = 0; c_done = 0; c_err = 0; c_tmo = 0;
  endtask

  task automatic tally();
    if (arbcy) c_arb++;
    if (adrcy) c_adr++;
    if (dtacy) c_dta++;
    if (owner) c_own++;
    if (locked) c_lck++;
    if (req_done != '0) c_done++;
    if (req_err != '0) c_err++;
    if (timeout_o) c_tmo++;
  endtask

  // Round-robin reference: first valid index at or after the start pointer.
  function automatic int rr_pick(input logic [NR-1:0] v, input int from);
    for (int k = 0; k < NR; k++) begin
      int i;
      i = (from + k) % NR;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  // Expected strobe durations of one whole transaction, from the bus-cycle rules.
  function automatic vec_t model_txn(input logic [NR-1:0] v, input logic [NR-1:0] lk,
                                     input int d, input bit drop, input int from);
    vec_t r;
    bit   lkd;
    r.v = v; r.lk = lk; r.d = d; r.drop = drop;
    r.sel = rr_pick(v, from);
    lkd   = lk[r.sel];
    r.dta = d;
    r.adr = lkd ? 3 : 1;
    r.own = lkd ? d + 3 : d + 1;
    r.lck = lkd ? d + 3 : 0;
    r.arb = lkd ? d + 5 : 2;
    return r;
  endfunction

  task automatic run_txn(input vec_t t, input string tag);
    logic [NR-1:0] done_v;
    logic [31:0]   sel_v;
    bit            got;
    int            cyc;
    clr_cnt();
    got = 1'b0; done_v = '0; sel_v = '0; cyc = 0;
    req_valid = t.v;
    req_lock  = t.lk;
    nub_ackn  = 1'b1;
    while (!got && cyc < 64) begin
      step();
      cyc++;
      tally();
      if (t.drop && arbcy) req_valid = '0;
      if (req_done != '0) begin
        got       = 1'b1;
        done_v    = req_done;
        sel_v     = 32'(req_sel);
        req_valid = '0;
      end
      nub_ackn = (dtacy && c_dta == t.d) ? 1'b0 : 1'b1;
    end
    req_valid = '0;
    nub_ackn  = 1'b1;
    step();
    tally();
    chk({tag, "_completed"}, 32'(got), 32'd1);
    chk({tag, "_sel"}, sel_v, 32'(t.sel));
    chk({tag, "_done_onehot"}, 32'(done_v), 32'(1) << t.sel);
    chk({tag, "_done_cycles"}, 32'(c_done), 32'd1);
    chk({tag, "_arbcy_cycles"}, 32'(c_arb), 32'(t.arb));
    chk({tag, "_adrcy_cycles"}, 32'(c_adr), 32'(t.adr));
    chk({tag, "_dtacy_cycles"}, 32'(c_dta), 32'(t.dta));
    chk({tag, "_owner_cycles"}, 32'(c_own), 32'(t.own));
    chk({tag, "_locked_cycles"}, 32'(c_lck), 32'(t.lck));
    chk({tag, "_err_cycles"}, 32'(c_err), 32'd0);
    chk({tag, "_timeout_cycles"}, 32'(c_tmo), 32'd0);
    rr_next = (t.sel + 1) % NR;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [8];
    vec_t rv;
    int   cnt;
    int   guard;

    tbl[0] = '{2'b01, 2'b00, 3, 1'b0, 0, 2, 1, 3, 4, 0};
    tbl[1] = '{2'b01, 2'b01, 2, 1'b0, 0, 7, 3, 2, 5, 5};
    tbl[2] = '{2'b10, 2'b00, 1, 1'b1, 1, 2, 1, 1, 2, 0};
    tbl[3] = '{2'b11, 2'b00, 2, 1'b0, 0, 2, 1, 2, 3, 0};
    tbl[4] = '{2'b11, 2'b00, 1, 1'b0, 1, 2, 1, 1, 2, 0};
    tbl[5] = '{2'b11, 2'b11, 1, 1'b0, 0, 6, 3, 1, 4, 4};
    tbl[6] = '{2'b11, 2'b00, 4, 1'b0, 1, 2, 1, 4, 5, 0};
    tbl[7] = '{2'b10, 2'b10, 3, 1'b1, 1, 8, 3, 3, 6, 6};

    nub_reset  = 1'b1;
    nub_rqstn  = 1'b1;
    nub_startn = 1'b1;
    nub_ackn   = 1'b1;
    arb_grant  = 1'b1;
    req_valid  = '0;
    req_lock   = '0;
    step();
    step();
    chk("reset_outputs", outs(), 32'd0);
    nub_reset = 1'b0;

    // Bus request still asserted by another master: stay in IDLE.
    nub_rqstn = 1'b0;
    req_valid = 2'b01;
    step();
    step();
    chk("rqst_blocks_arb", 32'(arbcy), 32'd0);
    req_valid = '0;
    nub_rqstn = 1'b1;
    step();

    for (int i = 0; i < 8; i++) run_txn(tbl[i], $sformatf("tbl%0d", i));

    // START and ACK together on an idle bus leave busy clear.
    nub_startn = 1'b0;
    nub_ackn   = 1'b0;
    step();
    chk("start_ack_same_clk_busy", 32'(busy), 32'd0);
    nub_startn = 1'b1;
    nub_ackn   = 1'b1;
    step();

    // Foreign transaction in progress: win only in the clock after its ACK.
    nub_startn = 1'b0;
    step();
    chk("foreign_start_busy", 32'(busy), 32'd1);
    nub_startn = 1'b1;
    req_valid  = 2'b01;
    req_lock   = 2'b00;
    step();
    req_valid = '0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("busy_hold_owner_%0d", i), 32'({owner, arbcy, busy}), 32'b011);
    end
    nub_ackn = 1'b0;
    step();
    chk("owner_after_foreign_ack", 32'({owner, adrcy, busy}), 32'b110);
    nub_ackn = 1'b1;
    guard = 0;
    while (req_done == '0 && guard < 20) begin
      step();
      guard++;
      nub_ackn = dtacy ? 1'b0 : 1'b1;
    end
    chk("busy_txn_done", 32'(req_done), 32'b01);
    nub_ackn = 1'b1;
    rr_next = 1;
    step();

    // Reset in the middle of DATA.
    req_valid = 2'b01;
    guard = 0;
    while (!dtacy && guard < 10) begin
      step();
      guard++;
    end
    chk("reset_reached_data", 32'(dtacy), 32'd1);
    nub_reset = 1'b1;
    req_valid = '0;
    nub_ackn  = 1'b0;
    step();
    chk("reset_mid_txn_outputs", outs(), 32'd0);
    nub_reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (req_done != '0) cnt++;
    end
    chk("reset_no_done", 32'(cnt), 32'd0);
    nub_ackn = 1'b1;
    rr_next = 0;
    run_txn(model_txn(2'b11, 2'b00, 2, 1'b0, rr_next), "post_reset_ptr");

    for (int i = 0; i < 25; i++) begin
      logic [NR-1:0] v, lk;
      v  = NR'($urandom_range(3, 1));
      lk = NR'($urandom_range(3, 0));
      rv = model_txn(v, lk, int'($urandom_range(4, 1)), bit'($urandom_range(1, 0)), rr_next);
      run_txn(rv, $sformatf("rnd%0d", i));
    end

    // Locked transaction whose target never acknowledges.
    req_valid = 2'b01;
    req_lock  = 2'b01;
    nub_ackn  = 1'b1;
    guard = 0;
    while (!dtacy && guard < 10) begin
      step();
      guard++;
      if (arbcy) req_valid = '0;
    end
    chk("noack_reached_data", 32'(dtacy), 32'd1);
    cnt = 1;
`ifdef NUBUS_MASTER_TIMEOUT_EN
    guard = 0;
    while (guard < 20) begin
      step();
      guard++;
      if (!dtacy) break;
      cnt++;
    end
    chk("tmo_data_cycles", 32'(cnt), 32'd5);
    chk("tmo_pulse", 32'({timeout_o, req_err, req_done}), 32'b1_01_01);
    chk("tmo_drop", 32'({dtacy, owner, locked}), 32'b000);
    step();
    chk("tmo_pulse_end", 32'({timeout_o, req_err, req_done}), 32'd0);
    chk("tmo_idle", 32'({arbcy, adrcy, dtacy, owner, locked}), 32'd0);
`else
    c_tmo = 0;
    for (int i = 0; i < 11; i++) begin
      step();
      if (dtacy) cnt++;
      if (timeout_o) c_tmo++;
    end
    chk("noack_dtacy_held", 32'(cnt), 32'd12);
    chk("noack_no_timeout", 32'(c_tmo), 32'd0);
    nub_ackn = 1'b0;
    step();
    nub_ackn = 1'b1;
    chk("noack_late_done", 32'({req_done, req_err, adrcy, locked}), 32'b01_00_1_1);
    step();
    chk("noack_release", 32'({owner, locked, arbcy}), 32'd0);
`endif
    req_lock = '0;
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/nubus_master_mc.md
NUBUS_MASTER_MC -- requirements
Module: nubus_master_mc

Interface
REQ-001 Parameter NUM_REQ, default 2, number of local requesters (range 1..8).
REQ-002 Parameter TMO_W, default 8, width of the ACK-wait timeout counter.
REQ-003 Parameter TMO_CYCLES, default 200, clocks allowed in DATA before abort (must be < 2**TMO_W).
REQ-004 nub_clkn  input  1  sole clock; all state changes on its rising edge.
REQ-005 nub_reset  input  1  reset, synchronous, active-high.
REQ-006 nub_rqstn, nub_startn, nub_ackn  input  1 each  NuBus RQST/START/ACK, active-low.
REQ-007 arb_grant  input  1  external arbiter grant, active-high.
REQ-008 req_valid, req_lock  input  NUM_REQ  per-requester transaction request and locked flag.
REQ-009 req_done, req_err  output  NUM_REQ  one-clock completion pulse and error flag, one-hot.
REQ-010 req_sel  output  $clog2(NUM_REQ) (min 1)  index of requester currently served.
REQ-011 arbcy, adrcy, dtacy, owner, busy, locked  output  1 each  bus-cycle status strobes, active-high.
REQ-012 timeout_o  output  1  one-clock pulse on ACK-wait abort.

Function
REQ-013 States: IDLE, ARB, LOCK_ATN, START, DATA, NULL_ATN; one-hot or encoded, designer's choice.
REQ-014 busy tracker: set when START & ~ACK while ~busy; hold while ~ACK; clear on ACK.
REQ-015 IDLE -> ARB when any req_valid and RQST deasserted; req_sel latched by round-robin, priority starting after last served index.
REQ-016 arbcy = 1 in ARB; arbdn internal flag = registered (arbcy & ~START), giving one-clock arbitration delay.
REQ-017 Win condition: arbcy & arbdn & arb_grant & ((~busy & ~START) | (busy & ACK)).
REQ-018 On win: owner set; go to LOCK_ATN if req_lock[req_sel], else START.
REQ-019 LOCK_ATN: one clock, adrcy=1, locked=1, then START.
REQ-020 START: adrcy=1 for exactly one clock, then DATA.
REQ-021 DATA: dtacy=1 until ACK sampled; on ACK pulse req_done[req_sel], req_err=0; go NULL_ATN if locked else IDLE.
REQ-022 NULL_ATN: one clock, adrcy=1, owner=1; locked clears on exit; then IDLE.
REQ-023 owner deasserts the clock after leaving DATA (non-locked) or NULL_ATN (locked); arbcy held through locked sequence.
REQ-024 req_valid dropping after ARB entry does not cancel the transaction.
REQ-025 Two requesters valid simultaneously: alternate strictly; NUM_REQ=1 degenerates to single-channel.
REQ-026 ACK and START in same clock while ~busy: busy stays 0.

Reset
REQ-027 nub_reset=1 forces IDLE, all outputs 0, busy=0, arbdn=0, counter=0, round-robin pointer=0, on the next rising edge, including mid-transaction.

Configuration
REQ-028 Macro NUBUS_MASTER_TIMEOUT_EN defined: counter increments each DATA clock; at TMO_CYCLES without ACK, abort: dtacy/owner/locked drop, timeout_o and req_done/req_err[req_sel] pulse, go IDLE.
REQ-029 Macro undefined: no counter logic, timeout_o tied 0, req_err tied 0, DATA waits indefinitely.

Structure
REQ-030 Shared package nubus_pkg holds state enum and default NUM_REQ/TMO constants.
REQ-031 Round-robin selector is sub-module nubus_rr_sel (NUM_REQ parameter, valid vector in, index and any-valid out).

Verification
REQ-032 Single req0 unlocked, grant=1, ACK 3 clocks after adrcy -> arbcy 2 clk, adrcy 1 clk, dtacy 3 clk, req_done[0] pulse.
REQ-033 req0 locked -> adrcy pulses at LOCK_ATN, START, NULL_ATN; locked=1 from LOCK_ATN through NULL_ATN.
REQ-034 req0,req1 held valid 4 transactions -> req_sel sequence 0,1,0,1.
REQ-035 busy=1 from foreign START, grant=1 -> owner rises only in clock after foreign ACK.
REQ-036 TIMEOUT_EN, TMO_CYCLES=5, no ACK -> timeout_o and req_err pulse after 5 DATA clocks, IDLE next.
REQ-037 nub_reset asserted in DATA -> all outputs 0 next clock, no req_done.
